// File: rtl/rv32i_instruction_encoder_pkg.sv
// Shared RV32I CPU definitions: instruction classes, base opcodes and encoder error causes.
// The instruction decoder imports the same package so both sides agree on these encodings.
package rv32i_instruction_encoder_pkg;

    typedef enum logic [2:0] {
        ClsLui    = 3'd0,
        ClsOpi    = 3'd1,
        ClsOp     = 3'd2,
        ClsBranch = 3'd3,
        ClsJal    = 3'd4,
        ClsJalr   = 3'd5,
        ClsLoad   = 3'd6,
        ClsStore  = 3'd7
    } instr_class_e;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcOpi    = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;

    localparam logic [2:0] ErrNone    = 3'd0;
    localparam logic [2:0] ErrIllegal = 3'd1;
    localparam logic [2:0] ErrRange   = 3'd2;
    localparam logic [2:0] ErrAlign   = 3'd3;

    // True when the two's-complement value lies within [lo, hi].
    function automatic logic in_srange(input logic [31:0] v, input int lo, input int hi);
        return ($signed(v) >= lo) && ($signed(v) <= hi);
    endfunction

endpackage

// File: rtl/rv32i_encode_fields.sv
// Combinational RV32I field packer and request checker; reports the lowest failing error code.
module rv32i_encode_fields
    import rv32i_instruction_encoder_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic [2:0]  err
);

    instr_class_e cls_e;
    logic         illegal;
    logic         range_bad;
    logic         misaligned;
    logic         is_shift;

    assign cls_e    = instr_class_e'(cls);
    assign is_shift = (cls_e == ClsOpi) && (funct3[1:0] == 2'b01);

    always_comb begin
        word       = '0;
        illegal    = 1'b0;
        range_bad  = 1'b0;
        misaligned = 1'b0;
        unique case (cls_e)
            ClsLui: begin
                word      = {imm[31:12], rd, OpcLui};
                range_bad = (imm[11:0] != 12'd0);
            end
            ClsOpi: begin
                illegal = alt && (funct3 != 3'b101);
                if (is_shift) begin
                    word      = {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, OpcOpi};
                    range_bad = (imm[31:5] != 27'd0);
                end else begin
                    word      = {imm[11:0], rs1, funct3, rd, OpcOpi};
                    range_bad = !in_srange(imm, -2048, 2047);
                end
            end
            ClsOp: begin
                word    = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, OpcOp};
                illegal = alt && (funct3 != 3'b000) && (funct3 != 3'b101);
            end
            ClsBranch: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OpcBranch};
                illegal    = (funct3 == 3'b010) || (funct3 == 3'b011);
                range_bad  = !in_srange(imm, -4096, 4095);
                misaligned = imm[0];
            end
            ClsJal: begin
                word       = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpcJal};
                range_bad  = !in_srange(imm, -(1 << 20), (1 << 20) - 1);
                misaligned = imm[0];
            end
            ClsJalr: begin
                word      = {imm[11:0], rs1, funct3, rd, OpcJalr};
                illegal   = (funct3 != 3'b000);
                range_bad = !in_srange(imm, -2048, 2047);
            end
            ClsLoad: begin
                word      = {imm[11:0], rs1, funct3, rd, OpcLoad};
                illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
                range_bad = !in_srange(imm, -2048, 2047);
            end
            ClsStore: begin
                word      = {imm[11:5], rs2, rs1, funct3, imm[4:0], OpcStore};
                illegal   = (funct3 > 3'b010);
                range_bad = !in_srange(imm, -2048, 2047);
            end
            default: ;
        endcase
    end

    assign err = illegal    ? ErrIllegal :
                 range_bad  ? ErrRange   :
                 misaligned ? ErrAlign   : ErrNone;

endmodule

// File: rtl/rv32i_instruction_encoder.sv
// Two-stage RV32I instruction encoder: stage 1 registers and checks a request,
// stage 2 holds the encoded word while the counter supplies its instruction-RAM address.
module rv32i_instruction_encoder
    import rv32i_instruction_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_class,
    input  logic [2:0]  in_funct3,
    input  logic        in_alt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        err_valid,
    output logic [2:0]  err_code,
    output logic [15:0] err_count
);

    logic        ready_en_q;
    logic        s1_valid_q;
    logic [2:0]  s1_class_q;
    logic [2:0]  s1_funct3_q;
    logic        s1_alt_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [31:0] s1_imm_q;
    logic [31:0] s1_word;
    logic [2:0]  s1_err;
    logic        s2_valid_q;
    logic [31:0] s2_word_q;
    logic [31:0] addr_q;
    logic        err_valid_q;
    logic [2:0]  err_code_q;
    logic [15:0] err_count_q;
    logic        out_fire;
    logic        s1_reject;
    logic        s1_advance;
    logic        in_fire;

    rv32i_encode_fields u_fields (
        .cls    (s1_class_q),
        .funct3 (s1_funct3_q),
        .alt    (s1_alt_q),
        .rd     (s1_rd_q),
        .rs1    (s1_rs1_q),
        .rs2    (s1_rs2_q),
        .imm    (s1_imm_q),
        .word   (s1_word),
        .err    (s1_err)
    );

    assign out_fire   = s2_valid_q && out_ready;
    assign s1_reject  = s1_valid_q && (s1_err != ErrNone);
    assign s1_advance = !s2_valid_q || out_fire || s1_reject;
    // ready_en_q keeps in_ready low while reset is asserted and until the first clock edge.
    assign in_ready   = ready_en_q && (!s1_valid_q || s1_advance);
    assign in_fire    = in_valid && in_ready;

    assign out_valid  = s2_valid_q;
    assign out_word   = s2_word_q;
    assign out_addr   = addr_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_count  = err_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q  <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_class_q  <= '0;
            s1_funct3_q <= '0;
            s1_alt_q    <= 1'b0;
            s1_rd_q     <= '0;
            s1_rs1_q    <= '0;
            s1_rs2_q    <= '0;
            s1_imm_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_word_q   <= '0;
            addr_q      <= BASE_ADDR;
            err_valid_q <= 1'b0;
            err_code_q  <= ErrNone;
            err_count_q <= '0;
        end else begin
            ready_en_q  <= 1'b1;
            err_valid_q <= 1'b0;
            if (flush) begin
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
                addr_q     <= BASE_ADDR;
            end else begin
                if (s1_reject) begin
                    err_valid_q <= 1'b1;
                    err_code_q  <= s1_err;
                    if (err_count_q != 16'hFFFF) begin
                        err_count_q <= err_count_q + 16'd1;
                    end
                end
                if (out_fire) begin
                    addr_q <= addr_q + 32'd4;
                end
                if (s1_valid_q && !s1_reject && s1_advance) begin
                    s2_valid_q <= 1'b1;
                    s2_word_q  <= s1_word;
                end else if (out_fire) begin
                    s2_valid_q <= 1'b0;
                end
                if (in_fire) begin
                    s1_valid_q  <= 1'b1;
                    s1_class_q  <= in_class;
                    s1_funct3_q <= in_funct3;
                    s1_alt_q    <= in_alt;
                    s1_rd_q     <= in_rd;
                    s1_rs1_q    <= in_rs1;
                    s1_rs2_q    <= in_rs2;
                    s1_imm_q    <= in_imm;
                end else if (s1_advance) begin
                    s1_valid_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32i_instruction_encoder.sv
// Scoreboard bench for rv32i_instruction_encoder: expected words/addresses queued at accept,
// compared when the DUT hands a word over.
module tb_rv32i_instruction_encoder;

    localparam logic [31:0] Base = 32'h0000_1000;

    localparam logic [2:0] CLui    = 3'd0;
    localparam logic [2:0] COpi    = 3'd1;
    localparam logic [2:0] COp     = 3'd2;
    localparam logic [2:0] CBranch = 3'd3;
    localparam logic [2:0] CJal    = 3'd4;
    localparam logic [2:0] CJalr   = 3'd5;
    localparam logic [2:0] CLoad   = 3'd6;
    localparam logic [2:0] CStore  = 3'd7;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_class = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_alt = 1'b0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [15:0] err_count;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] next_addr = Base;
    int          checks = 0;
    int          failures = 0;
    int          err_exp = 0;
    int          err_pulses = 0;
    int          n_accepts = 0;
    logic [31:0] hold_word;
    logic [31:0] hold_addr;

    rv32i_instruction_encoder #(.BASE_ADDR(Base)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_funct3 (in_funct3),
        .in_alt    (in_alt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .err_valid (err_valid),
        .err_code  (err_code),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    // Handshakes happen at the posedge following a negedge where valid&&ready holds.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_eq("out_unexpected", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check_eq("out_word", out_word, e.word);
                check_eq("out_addr", out_addr, e.addr);
            end
        end
        if (err_valid) err_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Must be called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [2:0] cls, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic [31:0] exp_word,
                        input logic [2:0] exp_err);
        logic acc;
        int   n;
        in_valid  = 1'b1;
        in_class  = cls;
        in_funct3 = f3;
        in_alt    = alt;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
        end
        if (acc) begin
            n_accepts++;
            if (exp_err == 3'd0) begin
                sb.push_back('{word: exp_word, addr: next_addr});
                next_addr = next_addr + 32'd4;
            end else begin
                err_exp++;
            end
        end else begin
            check_eq("accept_timeout", 32'(in_ready), 32'd1);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_err(input logic [2:0] code);
        repeat (3) @(negedge clk);
        check_eq("err_code", 32'(err_code), 32'(code));
        check_eq("err_count", 32'(err_count), 32'(err_exp));
        check_eq("err_pulses", 32'(err_pulses), 32'(err_exp));
        step();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check_eq("drain", 32'(sb.size()), 32'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_word", out_word, 32'd0);
        check_eq("rst_out_addr", out_addr, Base);
        check_eq("rst_err", {28'd0, err_valid, err_code}, 32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        #21 rst_n = 1'b1;
        step();
        @(negedge clk);
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
        step();

        // ADDI x1,x0,5 with latency check
        send(COpi, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 3'd0);
        @(negedge clk);
        check_eq("lat_cycle1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check_eq("lat_cycle2", 32'(out_valid), 32'd1);
        wait_drain();

        // SUB then LUI, back to back
        send(COp, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 3'd0);
        send(CLui, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 3'd0);
        wait_drain();

        // JAL then misaligned branch
        send(CJal, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h0080_00EF, 3'd0);
        send(CBranch, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 32'h0, 3'd3);
        check_err(3'd3);
        wait_drain();

        // Format coverage and boundary immediates, with rejects interleaved
        send(CStore, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'hFE20_AE23, 3'd0);
        send(CLoad, 3'b010, 1'b0, 5'd6, 5'd2, 5'd0, 32'd16, 32'h0101_2303, 3'd0);
        send(COpi, 3'b101, 1'b1, 5'd7, 5'd8, 5'd0, 32'd3, 32'h4034_5393, 3'd0);
        send(CBranch, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'hFE20_8CE3, 3'd0);
        send(CJalr, 3'b000, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0, 32'h0000_8067, 3'd0);
        send(CBranch, 3'b001, 1'b0, 5'd0, 5'd3, 5'd4, 32'd4094, 32'h7E41_9FE3, 3'd0);
        send(COpi, 3'b000, 1'b0, 5'd1, 5'd1, 5'd0, 32'hFFFF_F800, 32'h8000_8093, 3'd0);
        wait_drain();
        send(COpi, 3'b000, 1'b0, 5'd1, 5'd1, 5'd0, 32'd2048, 32'h0, 3'd2);
        check_err(3'd2);
        send(COpi, 3'b000, 1'b1, 5'd1, 5'd1, 5'd0, 32'd1, 32'h0, 3'd1);
        check_err(3'd1);
        send(CLoad, 3'b011, 1'b0, 5'd1, 5'd1, 5'd0, 32'd5000, 32'h0, 3'd1);
        check_err(3'd1);
        send(COpi, 3'b001, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32, 32'h0, 3'd2);
        check_err(3'd2);
        send(CLui, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h1234_5001, 32'h0, 3'd2);
        check_err(3'd2);
        send(CJal, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'h0010_0000, 32'h0, 3'd2);
        check_err(3'd2);
        send(CStore, 3'b011, 1'b0, 5'd0, 5'd1, 5'd2, 32'd0, 32'h0, 3'd1);
        check_err(3'd1);
        send(CJal, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd7, 32'h0, 3'd3);
        check_err(3'd3);
        wait_drain();

        // Back-to-back under a 5-cycle output stall
        out_ready = 1'b0;
        n_accepts = 0;
        fork
            begin
                for (int i = 1; i <= 4; i++) begin
                    w = (32'(i) << 20) | (32'(i) << 7) | 32'h13;
                    send(COpi, 3'b000, 1'b0, 5'(i), 5'd0, 5'd0, 32'(i), w, 3'd0);
                end
            end
            begin
                repeat (3) @(negedge clk);
                check_eq("stall_in_ready", 32'(in_ready), 32'd0);
                check_eq("stall_accepts", 32'(n_accepts), 32'd2);
                check_eq("stall_first", out_word, 32'h0010_0093);
                hold_word = out_word;
                hold_addr = out_addr;
                repeat (2) begin
                    @(negedge clk);
                    check_eq("hold_word", out_word, hold_word);
                    check_eq("hold_addr", out_addr, hold_addr);
                    check_eq("hold_valid", 32'(out_valid), 32'd1);
                end
                step();
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Flush coinciding with an output handshake and an input accept
        out_ready = 1'b0;
        send(COpi, 3'b000, 1'b0, 5'd9, 5'd0, 5'd0, 32'd9, 32'h0090_0493, 3'd0);
        @(negedge clk);
        @(negedge clk);
        check_eq("pre_flush_valid", 32'(out_valid), 32'd1);
        step();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_class  = COpi;
        in_funct3 = 3'b000;
        in_alt    = 1'b0;
        in_rd     = 5'd10;
        in_imm    = 32'd10;
        flush     = 1'b1;
        @(negedge clk);
        check_eq("flush_in_ready", 32'(in_ready), 32'd1);
        check_eq("flush_out_valid", 32'(out_valid), 32'd1);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        next_addr = Base;
        @(negedge clk);
        check_eq("post_flush_valid", 32'(out_valid), 32'd0);
        check_eq("post_flush_addr", out_addr, Base);
        check_eq("post_flush_errcnt", 32'(err_count), 32'(err_exp));
        step();
        send(COp, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 3'd0);
        wait_drain();

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0;
        send(CJalr, 3'b000, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0, 32'h0000_8067, 3'd0);
        send(CLui, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 3'd0);
        @(negedge clk);
        check_eq("mid_stall_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_in_ready", 32'(in_ready), 32'd0);
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_out_word", out_word, 32'd0);
        check_eq("arst_out_addr", out_addr, Base);
        check_eq("arst_err", {28'd0, err_valid, err_code}, 32'd0);
        check_eq("arst_err_count", 32'(err_count), 32'd0);
        sb.delete();
        next_addr  = Base;
        err_exp    = 0;
        err_pulses = 0;
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("arst_ready_again", 32'(in_ready), 32'd1);
        step();
        send(CLoad, 3'b010, 1'b0, 5'd6, 5'd2, 5'd0, 32'd16, 32'h0101_2303, 3'd0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
